udcnt_sweep_ctrl: RTL and testbench

Sequencer that drives the existing 4-bit up/down counter (udcnt) through repeated triangle sweeps between programmable low and high limits.
- Generates the counter's count-enable and up/down inputs and watches the counter's q output as feedback.
- Offers a start/busy/done handshake plus pause and stop controls, so test logic or a CPU-side block can request N sweeps without cycle-by-cycle control.

---
 rtl/udcnt_pkg.sv | 14 +
 rtl/udcnt_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_udcnt_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/udcnt_pkg.sv
// Shared types and constants for the udcnt counter and its sweep sequencer.
package udcnt_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAlign = 3'd1,
    StUp    = 3'd2,
    StDown  = 3'd3,
    StDone  = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/udcnt_sweep_ctrl.sv
// Drives a udcnt counter through repeated lo..hi triangle sweeps, using its q output as feedback.
module udcnt_sweep_ctrl
  import udcnt_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter int unsigned SW_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [SW_W-1:0]  n_sweeps,
  input  logic [WIDTH-1:0] q,
  output logic             cnt_en,
  output logic             cnt_ud,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SW_W-1:0]  sweep_cnt
);

  sweep_state_t     state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SW_W-1:0]  n_q, n_d;
  logic [SW_W-1:0]  sweep_q, sweep_d;
  logic             err_q, err_d;
  logic [SW_W-1:0]  sweep_inc;

  assign sweep_inc = sweep_q + SW_W'(1);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    sweep_d = sweep_q;
    err_d   = err_q;
    cnt_en  = 1'b0;
    cnt_ud  = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (hi > lo) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            sweep_d = '0;
            err_d   = 1'b0;
            state_d = StAlign;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAlign: begin
        busy   = 1'b1;
        cnt_ud = (q < lo_q);
        if (stop) begin
          state_d = StIdle;
        end else if (!pause) begin
          if (q == lo_q) begin
            state_d = StUp;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StUp: begin
        busy = 1'b1;
        if (stop) begin
          state_d = StIdle;
        end else if (!pause) begin
          cnt_en = 1'b1;
          // Turn one step early so q lands on hi as DOWN begins.
          if (q == hi_q - WIDTH'(1)) state_d = StDown;
        end
      end
      StDown: begin
        busy   = 1'b1;
        cnt_ud = 1'b0;
        if (stop) begin
          state_d = StIdle;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (q == lo_q + WIDTH'(1)) begin
            sweep_d = sweep_inc;
            if ((n_q != '0) && (sweep_inc == n_q)) state_d = StDone;
            else                                   state_d = StUp;
          end
        end
      end
      StDone: begin
        done    = !stop;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      sweep_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
    end
  end

  assign err       = err_q;
  assign sweep_cnt = sweep_q;

endmodule

// File: tb/tb_udcnt_sweep_ctrl.sv
// Directed bench: udcnt_sweep_ctrl closed-loop with a small behavioural up/down counter.
module tb_udcnt_sweep_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SW_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [WIDTH-1:0] lo = '0, hi = '0;
  logic [SW_W-1:0]  n_sweeps = '0;
  logic [WIDTH-1:0] q;
  logic             cnt_en, cnt_ud, busy, done, err;
  logic [SW_W-1:0]  sweep_cnt;

  // Counter model with a bench-side preload.
  logic             ld = 1'b0;
  logic [WIDTH-1:0] ld_val = '0;
  logic [WIDTH-1:0] cnt_q = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ld)          cnt_q <= ld_val;
    else if (cnt_en) cnt_q <= cnt_ud ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  assign q = cnt_q;

  udcnt_sweep_ctrl #(.WIDTH(WIDTH), .SW_W(SW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .lo        (lo),
    .hi        (hi),
    .n_sweeps  (n_sweeps),
    .q         (q),
    .cnt_en    (cnt_en),
    .cnt_ud    (cnt_ud),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cnt(input logic [WIDTH-1:0] v);
    ld = 1'b1; ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_cnt(4'd0);
    checks++;
    if ({cnt_en, cnt_ud, busy, done, err} !== 5'b01000 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: en/ud/busy/done/err=%b sweep=%0d want 01000 sweep=0",
               {cnt_en, cnt_ud, busy, done, err}, sweep_cnt);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_sweep();
    int exp_q [16] = '{0, 1, 2, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};
    lo = 4'd2; hi = 4'd5; n_sweeps = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q !== exp_q[i] || done !== (i == 15) || busy !== (i < 15)) begin
        errors++;
        $display("FAIL basic[%0d]: q=%0d done=%b busy=%b want q=%0d done=%b busy=%b",
                 i, q, done, busy, exp_q[i], i == 15, i < 15);
      end
      if (i < 15) tick();
    end
    checks++;
    if (sweep_cnt !== 8'd2) begin
      errors++;
      $display("FAIL basic_sweep_cnt: got %0d want 2", sweep_cnt);
    end
    tick();
    checks++;
    if (q !== 4'd2 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: q=%0d done=%b busy=%b want q=2 done=0 busy=0", q, done, busy);
    end
  endtask

  task automatic test_align_down();
    int exp_q [10] = '{9, 8, 7, 6, 5, 4, 3, 3, 4, 3};
    load_cnt(4'd9);
    lo = 4'd3; hi = 4'd4; n_sweeps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q !== exp_q[i] || done !== (i == 9) || (i < 6 && cnt_ud !== 1'b0)) begin
        errors++;
        $display("FAIL align[%0d]: q=%0d done=%b ud=%b want q=%0d done=%b",
                 i, q, done, cnt_ud, exp_q[i], i == 9);
      end
      if (i < 9) tick();
    end
    checks++;
    if (sweep_cnt !== 8'd1) begin
      errors++;
      $display("FAIL align_sweep_cnt: got %0d want 1", sweep_cnt);
    end
    tick();
  endtask

  task automatic test_limit_err();
    lo = 4'd6; hi = 4'd6; start = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL err_start_en: got %b want 0", cnt_en);
    end
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || cnt_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_done: done=%b err=%b en=%b busy=%b want 1 1 0 0", done, err, cnt_en, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || cnt_en !== 1'b0 || q !== 4'd3) begin
      errors++;
      $display("FAIL err_hold: done=%b err=%b en=%b q=%0d want 0 1 0 3", done, err, cnt_en, q);
    end
  endtask

  task automatic test_pause_stop();
    lo = 4'd0; hi = 4'd15; n_sweeps = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ps_start: err=%b busy=%b want 0 1", err, busy);
    end
    for (int k = 0; k < 40 && q != 4'd10; k++) tick();
    checks++;
    if (q !== 4'd10 || cnt_ud !== 1'b1) begin
      errors++;
      $display("FAIL ps_reach10: q=%0d ud=%b want 10 1", q, cnt_ud);
    end
    pause = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (q !== 4'd10 || cnt_en !== 1'b0 || busy !== 1'b1 || cnt_ud !== 1'b1) begin
        errors++;
        $display("FAIL ps_hold[%0d]: q=%0d en=%b busy=%b ud=%b want 10 0 1 1",
                 k, q, cnt_en, busy, cnt_ud);
      end
    end
    pause = 1'b0;
    tick();
    checks++;
    if (q !== 4'd11) begin
      errors++;
      $display("FAIL ps_resume: q=%0d want 11", q);
    end
    for (int k = 0; k < 40 && !(q == 4'd7 && cnt_ud == 1'b0); k++) tick();
    checks++;
    if (q !== 4'd7 || cnt_ud !== 1'b0) begin
      errors++;
      $display("FAIL ps_reach7: q=%0d ud=%b want 7 0", q, cnt_ud);
    end
    stop = 1'b1;
    #1;
    checks++;
    if (cnt_en !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ps_stop_comb: en=%b done=%b want 0 0", cnt_en, done);
    end
    tick();
    stop = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 4'd7 || sweep_cnt !== 8'd0) begin
        errors++;
        $display("FAIL ps_stopped[%0d]: busy=%b done=%b q=%0d sweep=%0d want 0 0 7 0",
                 k, busy, done, q, sweep_cnt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int exp_q [9] = '{1, 1, 2, 3, 2, 1, 2, 3, 2};
    lo = 4'd5; hi = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_err_set: err=%b want 1", err);
    end
    lo = 4'd1; hi = 4'd3; n_sweeps = 8'd0; start = 1'b1;
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_err_clear: err=%b busy=%b want 0 1", err, busy);
    end
    // Start while busy must not relatch these.
    lo = 4'd0; hi = 4'd15; n_sweeps = 8'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && q != 4'd1; k++) tick();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (q !== exp_q[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_q[%0d]: q=%0d busy=%b want q=%0d busy=1", i, q, busy, exp_q[i]);
      end
      if (i < 8) tick();
    end
    checks++;
    if (cnt_ud !== 1'b0 || sweep_cnt !== 8'd1) begin
      errors++;
      $display("FAIL b2b_pre_rst: ud=%b sweep=%0d want 0 1", cnt_ud, sweep_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_ud, busy, done, err} !== 5'b01000 || sweep_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_rst: en/ud/busy/done/err=%b sweep=%0d want 01000 sweep=0",
               {cnt_en, cnt_ud, busy, done, err}, sweep_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: busy=%b en=%b want 0 0", busy, cnt_en);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_align_down();
    test_limit_err();
    test_pause_stop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
